// File: rtl/instr_classifier.sv
// instr_classifier
//   Maps a decoded instruction ID to an operand format and a functional
//   class. Combinational outputs feed same-cycle consumers (NPC branch/jump
//   detection); a registered copy with enable feeds the next pipeline stage.
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears the registered outputs
//   en        registered-output update enable (0 = stall/hold)
//   instr     instruction ID
//   format    combinational format code (NONE=0, R=1, I=2, J=3)
//   func      combinational functional class
//   is_link   combinational; 1 for JAL and JALR
//   ri        combinational; reserved/unknown instruction ID
//   format_q  registered format
//   func_q    registered func
//   ri_q      registered ri
module instr_classifier #(
    parameter int unsigned WIDTH_INSTR  = 6,
    parameter int unsigned WIDTH_FORMAT = 3,
    parameter int unsigned WIDTH_FUNC   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [WIDTH_INSTR-1:0]  instr,
    output logic [WIDTH_FORMAT-1:0] format,
    output logic [WIDTH_FUNC-1:0]   func,
    output logic                    is_link,
    output logic                    ri,
    output logic [WIDTH_FORMAT-1:0] format_q,
    output logic [WIDTH_FUNC-1:0]   func_q,
    output logic                    ri_q
);

    // Format codes
    localparam logic [WIDTH_FORMAT-1:0] FMT_NONE = WIDTH_FORMAT'(0);
    localparam logic [WIDTH_FORMAT-1:0] FMT_R    = WIDTH_FORMAT'(1);
    localparam logic [WIDTH_FORMAT-1:0] FMT_I    = WIDTH_FORMAT'(2);
    localparam logic [WIDTH_FORMAT-1:0] FMT_J    = WIDTH_FORMAT'(3);

    // Functional-class codes
    localparam logic [WIDTH_FUNC-1:0] FN_OTHER  = WIDTH_FUNC'(0);
    localparam logic [WIDTH_FUNC-1:0] FN_CALC_R = WIDTH_FUNC'(1);
    localparam logic [WIDTH_FUNC-1:0] FN_SHIFT  = WIDTH_FUNC'(2);
    localparam logic [WIDTH_FUNC-1:0] FN_MULDIV = WIDTH_FUNC'(3);
    localparam logic [WIDTH_FUNC-1:0] FN_CALC_I = WIDTH_FUNC'(4);
    localparam logic [WIDTH_FUNC-1:0] FN_LOAD   = WIDTH_FUNC'(5);
    localparam logic [WIDTH_FUNC-1:0] FN_STORE  = WIDTH_FUNC'(6);
    localparam logic [WIDTH_FUNC-1:0] FN_BRANCH = WIDTH_FUNC'(7);
    localparam logic [WIDTH_FUNC-1:0] FN_JUMP   = WIDTH_FUNC'(8);
    localparam logic [WIDTH_FUNC-1:0] FN_CP0    = WIDTH_FUNC'(9);

    // Last ID of each contiguous instruction group
    localparam logic [WIDTH_INSTR-1:0] ID_NOP     = WIDTH_INSTR'(0);
    localparam logic [WIDTH_INSTR-1:0] ID_CALC_R  = WIDTH_INSTR'(10);
    localparam logic [WIDTH_INSTR-1:0] ID_SHIFT   = WIDTH_INSTR'(16);
    localparam logic [WIDTH_INSTR-1:0] ID_MULDIV  = WIDTH_INSTR'(24);
    localparam logic [WIDTH_INSTR-1:0] ID_CALC_I  = WIDTH_INSTR'(32);
    localparam logic [WIDTH_INSTR-1:0] ID_LOAD    = WIDTH_INSTR'(37);
    localparam logic [WIDTH_INSTR-1:0] ID_STORE   = WIDTH_INSTR'(40);
    localparam logic [WIDTH_INSTR-1:0] ID_BRANCH  = WIDTH_INSTR'(46);
    localparam logic [WIDTH_INSTR-1:0] ID_JUMP_J  = WIDTH_INSTR'(48);
    localparam logic [WIDTH_INSTR-1:0] ID_JUMP_R  = WIDTH_INSTR'(50);
    localparam logic [WIDTH_INSTR-1:0] ID_CP0     = WIDTH_INSTR'(53);
    localparam logic [WIDTH_INSTR-1:0] ID_JAL     = WIDTH_INSTR'(48);
    localparam logic [WIDTH_INSTR-1:0] ID_JALR    = WIDTH_INSTR'(50);

    // Range decode: groups are contiguous and ascending, so the first
    // upper bound that covers instr selects the class.
    always_comb begin
        format = FMT_NONE;
        func   = FN_OTHER;
        ri     = 1'b0;
        if (instr == ID_NOP) begin
            format = FMT_NONE;
            func   = FN_OTHER;
        end else if (instr <= ID_CALC_R) begin
            format = FMT_R;
            func   = FN_CALC_R;
        end else if (instr <= ID_SHIFT) begin
            format = FMT_R;
            func   = FN_SHIFT;
        end else if (instr <= ID_MULDIV) begin
            format = FMT_R;
            func   = FN_MULDIV;
        end else if (instr <= ID_CALC_I) begin
            format = FMT_I;
            func   = FN_CALC_I;
        end else if (instr <= ID_LOAD) begin
            format = FMT_I;
            func   = FN_LOAD;
        end else if (instr <= ID_STORE) begin
            format = FMT_I;
            func   = FN_STORE;
        end else if (instr <= ID_BRANCH) begin
            format = FMT_I;
            func   = FN_BRANCH;
        end else if (instr <= ID_JUMP_J) begin
            format = FMT_J;
            func   = FN_JUMP;
        end else if (instr <= ID_JUMP_R) begin
            format = FMT_R;
            func   = FN_JUMP;
        end else if (instr <= ID_CP0) begin
            format = FMT_R;
            func   = FN_CP0;
        end else begin
            ri     = 1'b1;
        end
    end

    // Link-register writers
    always_comb begin
        is_link = (instr == ID_JAL) || (instr == ID_JALR);
    end

    // Pipeline copy; reset state equals the NOP classification so a
    // flushed stage reads as NOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            format_q <= FMT_NONE;
            func_q   <= FN_OTHER;
            ri_q     <= 1'b0;
        end else if (en) begin
            format_q <= format;
            func_q   <= func;
            ri_q     <= ri;
        end
    end

endmodule

// File: tb/tb_instr_classifier.sv
// tb_instr_classifier
//   Self-checking bench for instr_classifier: directed sweep plus random
//   traffic compared against a table-driven reference classification.
module tb_instr_classifier;

    logic       clk;
    logic       reset;
    logic       en;
    logic [5:0] instr;
    logic [2:0] format;
    logic [3:0] func;
    logic       is_link;
    logic       ri;
    logic [2:0] format_q;
    logic [3:0] func_q;
    logic       ri_q;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Expected registered state
    int exp_fmt_q = 0;
    int exp_fn_q  = 0;
    int exp_ri_q  = 0;

    instr_classifier dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .instr    (instr),
        .format   (format),
        .func     (func),
        .is_link  (is_link),
        .ri       (ri),
        .format_q (format_q),
        .func_q   (func_q),
        .ri_q     (ri_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference classification from the instruction-group table.
    function automatic void ref_class(input int id, output int fmt, output int fn,
                                      output int r, output int lnk);
        int last_id [11] = '{0, 10, 16, 24, 32, 37, 40, 46, 48, 50, 53};
        int grp_fmt [11] = '{0,  1,  1,  1,  2,  2,  2,  2,  3,  1,  1};
        int grp_fn  [11] = '{0,  1,  2,  3,  4,  5,  6,  7,  8,  8,  9};
        fmt = 0;
        fn  = 0;
        r   = 1;
        for (int g = 0; g < 11; g++) begin
            if (id <= last_id[g]) begin
                fmt = grp_fmt[g];
                fn  = grp_fn[g];
                r   = 0;
                break;
            end
        end
        lnk = (id == 48 || id == 50) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        int f, fn, r, l;
        ref_class(int'(instr), f, fn, r, l);
        check({tag, ".format"},  32'(format),  32'(f));
        check({tag, ".func"},    32'(func),    32'(fn));
        check({tag, ".ri"},      32'(ri),      32'(r));
        check({tag, ".is_link"}, 32'(is_link), 32'(l));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".format_q"}, 32'(format_q), 32'(exp_fmt_q));
        check({tag, ".func_q"},   32'(func_q),   32'(exp_fn_q));
        check({tag, ".ri_q"},     32'(ri_q),     32'(exp_ri_q));
    endtask

    // Drive inputs, advance one edge, update the expected registered state.
    task automatic step(input logic rst_v, input logic en_v, input logic [5:0] id);
        int f, fn, r, l;
        @(negedge clk);
        reset = rst_v;
        en    = en_v;
        instr = id;
        ref_class(int'(id), f, fn, r, l);
        @(posedge clk);
        if (rst_v) begin
            exp_fmt_q = 0; exp_fn_q = 0; exp_ri_q = 0;
        end else if (en_v) begin
            exp_fmt_q = f; exp_fn_q = fn; exp_ri_q = r;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        instr = 6'd38;

        // Reset with en=1 and a STORE on instr: reset wins
        step(1'b1, 1'b1, 6'd38);
        check_regs("reset");
        check("reset.format_q_const", 32'(format_q), 32'd0);

        // Full combinational sweep
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            instr = 6'(i);
            #1;
            check_comb($sformatf("sweep%0d", i));
        end

        // Spot values straight from the table
        instr = 6'd41; #1;
        check("beq.format", 32'(format), 32'd2);
        check("beq.func",   32'(func),   32'd7);
        instr = 6'd50; #1;
        check("jalr.format",  32'(format),  32'd1);
        check("jalr.func",    32'(func),    32'd8);
        check("jalr.is_link", 32'(is_link), 32'd1);
        instr = 6'd49; #1;
        check("jr.is_link", 32'(is_link), 32'd0);
        instr = 6'd60; #1;
        check("rsvd60.ri",   32'(ri),   32'd1);
        check("rsvd60.func", 32'(func), 32'd0);
        instr = 6'd53; #1;
        check("eret.func", 32'(func), 32'd9);
        check("eret.ri",   32'(ri),   32'd0);

        // Capture then stall
        step(1'b0, 1'b1, 6'd37);
        check("lw.format_q", 32'(format_q), 32'd2);
        check("lw.func_q",   32'(func_q),   32'd5);
        step(1'b0, 1'b0, 6'd47);
        check("hold.format_q", 32'(format_q), 32'd2);
        check("hold.func_q",   32'(func_q),   32'd5);
        check_comb("hold.comb");

        // Reserved then ordinary capture
        step(1'b0, 1'b1, 6'd55);
        check("rsvd55.ri_q", 32'(ri_q), 32'd1);
        step(1'b0, 1'b1, 6'd1);
        check("addu.ri_q",   32'(ri_q),   32'd0);
        check("addu.func_q", 32'(func_q), 32'd1);

        // Reset during stall still clears
        step(1'b0, 1'b1, 6'd48);
        step(1'b1, 1'b0, 6'd48);
        check_regs("reset_stalled");

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 6'($urandom_range(0, 63)));
            check_regs($sformatf("rnd%0d", n));
            check_comb($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
